// File: rtl/imm_pkg.sv
// Shared definitions for the RV32/RV64 immediate generator: opcodes,
// format codes and the XLEN legality check.
package imm_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned FMT_W  = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

  // Code 7 is reserved.
  typedef enum logic [FMT_W-1:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  function automatic bit xlen_legal(int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word to sign-extended
// immediate, format code and unknown-opcode flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   imm_c,
  output fmt_e              fmt_c,
  output logic              bad_op_c
);

  localparam bit IS64 = (XLEN == 64);

  logic [OPC_W-1:0] opc;
  logic             shift_op;
  logic [31:0]      imm_i;
  logic [31:0]      imm_s;
  logic [31:0]      imm_b;
  logic [31:0]      imm_u;
  logic [31:0]      imm_j;
  logic [5:0]       shamt_op;
  logic [5:0]       shamt_w;

  assign opc      = inst[6:0];
  assign shift_op = (inst[13:12] == 2'b01);  // funct3 001 or 101
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {inst[31:12], 12'b0};
  assign imm_j    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  // RV64 OP-IMM shifts use a 6-bit shamt; word shifts and RV32 use 5 bits.
  assign shamt_op = IS64 ? inst[25:20] : {1'b0, inst[24:20]};
  assign shamt_w  = {1'b0, inst[24:20]};

  always_comb begin
    imm_c    = '0;
    fmt_c    = FMT_NONE;
    bad_op_c = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        imm_c = XLEN'($signed(imm_i));
        fmt_c = FMT_I;
      end
      OPC_OP_IMM: begin
        if (shift_op) begin
          imm_c = XLEN'(shamt_op);
          fmt_c = FMT_SHAMT;
        end else begin
          imm_c = XLEN'($signed(imm_i));
          fmt_c = FMT_I;
        end
      end
      OPC_OP_IMM_32: begin
        if (!IS64) begin
          bad_op_c = 1'b1;
        end else if (shift_op) begin
          imm_c = XLEN'(shamt_w);
          fmt_c = FMT_SHAMT;
        end else begin
          imm_c = XLEN'($signed(imm_i));
          fmt_c = FMT_I;
        end
      end
      OPC_STORE: begin
        imm_c = XLEN'($signed(imm_s));
        fmt_c = FMT_S;
      end
      OPC_BRANCH: begin
        imm_c = XLEN'($signed(imm_b));
        fmt_c = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_c = XLEN'($signed(imm_u));
        fmt_c = FMT_U;
      end
      OPC_JAL: begin
        imm_c = XLEN'($signed(imm_j));
        fmt_c = FMT_J;
      end
      OPC_OP:    bad_op_c = 1'b0;
      OPC_OP_32: bad_op_c = !IS64;
      default:   bad_op_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on the input side, results held
// in a 2-entry skid buffer with synchronous flush.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [FMT_W-1:0]  out_fmt,
  output logic              out_bad_op,
  output logic [TAG_W-1:0]  out_tag
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             bad_op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t dec_entry;
  entry_t e0_q, e0_n;
  entry_t e1_q, e1_n;
  logic   e0_v_q, e0_v_n;
  logic   e1_v_q, e1_v_n;
  logic   enq;
  logic   deq;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst     (in_inst),
    .imm_c    (dec_entry.imm),
    .fmt_c    (dec_entry.fmt),
    .bad_op_c (dec_entry.bad_op)
  );
  assign dec_entry.tag = in_tag;

  assign enq = in_valid & ~e1_v_q;
  assign deq = e0_v_q & out_ready;

  // Next-state: flush wins; otherwise FIFO order with E1 refilling E0.
  always_comb begin
    e0_n   = e0_q;
    e1_n   = e1_q;
    e0_v_n = e0_v_q;
    e1_v_n = e1_v_q;
    if (flush) begin
      e0_v_n = 1'b0;
      e1_v_n = 1'b0;
    end else if (deq) begin
      if (e1_v_q) begin
        e0_n   = e1_q;
        e1_v_n = 1'b0;
      end else begin
        e0_v_n = enq;
        if (enq) e0_n = dec_entry;
      end
    end else if (enq) begin
      if (!e0_v_q) begin
        e0_n   = dec_entry;
        e0_v_n = 1'b1;
      end else begin
        e1_n   = dec_entry;
        e1_v_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q   <= '0;
      e1_q   <= '0;
      e0_v_q <= 1'b0;
      e1_v_q <= 1'b0;
    end else begin
      e0_q   <= e0_n;
      e1_q   <= e1_n;
      e0_v_q <= e0_v_n;
      e1_v_q <= e1_v_n;
    end
  end

  assign in_ready   = ~e1_v_q;
  assign out_valid  = e0_v_q;
  assign out_imm    = e0_q.imm;
  assign out_fmt    = e0_q.fmt;
  assign out_bad_op = e0_q.bad_op;
  assign out_tag    = e0_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance,
// hand-computed expected immediates, backpressure, flush and async reset.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  logic flush;

  logic        iv32, ir32, ov32, or32, ob32;
  logic [31:0] ii32, it32, oi32, ot32;
  logic [2:0]  of32;

  logic        iv64, ir64, ov64, or64, ob64;
  logic [31:0] ii64, it64, ot64;
  logic [63:0] oi64;
  logic [2:0]  of64;

  int n_cmp;
  int n_bad;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv32), .in_ready(ir32), .in_inst(ii32), .in_tag(it32),
    .out_valid(ov32), .out_ready(or32), .out_imm(oi32), .out_fmt(of32),
    .out_bad_op(ob32), .out_tag(ot32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv64), .in_ready(ir64), .in_inst(ii64), .in_tag(it64),
    .out_valid(ov64), .out_ready(or64), .out_imm(oi64), .out_fmt(of64),
    .out_bad_op(ob64), .out_tag(ot64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset handshake: got valid=%b ready=%b expected valid=0 ready=1", ov32, ir32);
    end
    n_cmp++;
    if (oi32 !== 32'h0 || of32 !== 3'd0 || ob32 !== 1'b0 || ot32 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset payload: got imm=%h fmt=%0d bad=%b tag=%h expected all zero", oi32, of32, ob32, ot32);
    end
    n_cmp++;
    if (ov64 !== 1'b0 || ir64 !== 1'b1 || oi64 !== 64'h0) begin
      n_bad++;
      $display("FAIL reset64: got valid=%b ready=%b imm=%h expected 0/1/0", ov64, ir64, oi64);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream32();
    logic [31:0] ins [10];
    logic [31:0] imm [10];
    logic [2:0]  fmt [10];
    logic        bad [10];
    ins = '{32'hFFF00093, 32'hFE112E23, 32'h00000863, 32'hFF9FF06F, 32'h123452B7,
            32'h00309093, 32'h00000033, 32'h0000007F, 32'h0000001B, 32'h0000003B};
    imm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000010, 32'hFFFFFFF8, 32'h12345000,
            32'h00000003, 32'h0, 32'h0, 32'h0, 32'h0};
    fmt = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    bad = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    or32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iv32 = 1'b1;
      ii32 = ins[i];
      it32 = 32'(1000 + i);
      step();
      n_cmp++;
      if (ov32 !== 1'b1 || ir32 !== 1'b1) begin
        n_bad++;
        $display("FAIL stream32[%0d] handshake: got valid=%b ready=%b expected 1/1", i, ov32, ir32);
      end
      n_cmp++;
      if (oi32 !== imm[i] || of32 !== fmt[i] || ob32 !== bad[i]) begin
        n_bad++;
        $display("FAIL stream32[%0d] decode: got imm=%h fmt=%0d bad=%b expected imm=%h fmt=%0d bad=%b",
                 i, oi32, of32, ob32, imm[i], fmt[i], bad[i]);
      end
      n_cmp++;
      if (ot32 !== 32'(1000 + i)) begin
        n_bad++;
        $display("FAIL stream32[%0d] tag: got %0d expected %0d", i, ot32, 1000 + i);
      end
    end
    iv32 = 1'b0;
    step();
    n_cmp++;
    if (ov32 !== 1'b0 || ot32 !== 32'd1009) begin
      n_bad++;
      $display("FAIL stream32 drain: got valid=%b tag=%0d expected valid=0 tag=1009", ov32, ot32);
    end
  endtask

  task automatic test_stream64();
    logic [31:0] ins [8];
    logic [63:0] imm [8];
    logic [2:0]  fmt [8];
    logic        bad [8];
    ins = '{32'h800002B7, 32'h03F09093, 32'h03F0909B, 32'hFFF00093,
            32'h0000003B, 32'h0000001B, 32'hFE112E23, 32'h0000007F};
    imm = '{64'hFFFFFFFF80000000, 64'd63, 64'd31, 64'hFFFFFFFFFFFFFFFF,
            64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h0};
    fmt = '{3'd4, 3'd6, 3'd6, 3'd1, 3'd0, 3'd1, 3'd2, 3'd0};
    bad = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    or64 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv64 = 1'b1;
      ii64 = ins[i];
      it64 = 32'(2000 + i);
      step();
      n_cmp++;
      if (ov64 !== 1'b1 || ot64 !== 32'(2000 + i)) begin
        n_bad++;
        $display("FAIL stream64[%0d] valid/tag: got valid=%b tag=%0d expected 1/%0d", i, ov64, ot64, 2000 + i);
      end
      n_cmp++;
      if (oi64 !== imm[i] || of64 !== fmt[i] || ob64 !== bad[i]) begin
        n_bad++;
        $display("FAIL stream64[%0d] decode: got imm=%h fmt=%0d bad=%b expected imm=%h fmt=%0d bad=%b",
                 i, oi64, of64, ob64, imm[i], fmt[i], bad[i]);
      end
    end
    iv64 = 1'b0;
    step();
    n_cmp++;
    if (ov64 !== 1'b0) begin
      n_bad++;
      $display("FAIL stream64 drain: got valid=%b expected 0", ov64);
    end
  endtask

  task automatic test_backpressure();
    or32 = 1'b0;
    iv32 = 1'b1;
    ii32 = 32'h00000863;
    it32 = 32'd200;
    step();
    n_cmp++;
    if (ir32 !== 1'b1 || ov32 !== 1'b1 || ot32 !== 32'd200) begin
      n_bad++;
      $display("FAIL bp first accept: got ready=%b valid=%b tag=%0d expected 1/1/200", ir32, ov32, ot32);
    end
    ii32 = 32'hFF9FF06F;
    it32 = 32'd201;
    step();
    ii32 = 32'h123452B7;
    it32 = 32'd202;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (ir32 !== 1'b0 || ov32 !== 1'b1 || ot32 !== 32'd200) begin
        n_bad++;
        $display("FAIL bp full[%0d]: got ready=%b valid=%b tag=%0d expected 0/1/200", c, ir32, ov32, ot32);
      end
      if (c < 2) step();
    end
    or32 = 1'b1;
    step();
    n_cmp++;
    if (ov32 !== 1'b1 || ot32 !== 32'd201 || oi32 !== 32'hFFFFFFF8 || ir32 !== 1'b1) begin
      n_bad++;
      $display("FAIL bp drain 2nd: got valid=%b tag=%0d imm=%h ready=%b expected 1/201/fffffff8/1",
               ov32, ot32, oi32, ir32);
    end
    step();
    n_cmp++;
    if (ov32 !== 1'b1 || ot32 !== 32'd202 || oi32 !== 32'h12345000) begin
      n_bad++;
      $display("FAIL bp held input: got valid=%b tag=%0d imm=%h expected 1/202/12345000", ov32, ot32, oi32);
    end
    iv32 = 1'b0;
    step();
    n_cmp++;
    if (ov32 !== 1'b0 || ot32 !== 32'd202) begin
      n_bad++;
      $display("FAIL bp empty hold: got valid=%b tag=%0d expected 0/202", ov32, ot32);
    end
  endtask

  task automatic test_flush();
    // Flush with one entry and a simultaneous enqueue: both discarded.
    or32 = 1'b0;
    iv32 = 1'b1;
    ii32 = 32'hFFF00093;
    it32 = 32'd300;
    step();
    it32 = 32'd301;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      n_bad++;
      $display("FAIL flush one+enq: got valid=%b ready=%b expected 0/1", ov32, ir32);
    end
    // Fill both entries, then flush with in_valid still asserted.
    it32 = 32'd310;
    step();
    it32 = 32'd311;
    step();
    it32 = 32'd312;
    n_cmp++;
    if (ir32 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush prefill: got ready=%b expected 0", ir32);
    end
    flush = 1'b1;
    or32 = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      n_bad++;
      $display("FAIL flush full: got valid=%b ready=%b expected 0/1", ov32, ir32);
    end
    it32 = 32'd320;
    ii32 = 32'hFE112E23;
    step();
    n_cmp++;
    if (ov32 !== 1'b1 || ot32 !== 32'd320 || oi32 !== 32'hFFFFFFFC) begin
      n_bad++;
      $display("FAIL flush recovery: got valid=%b tag=%0d imm=%h expected 1/320/fffffffc", ov32, ot32, oi32);
    end
    iv32 = 1'b0;
    step();
    n_cmp++;
    if (ov32 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush tail: got valid=%b expected 0 (tag=%0d)", ov32, ot32);
    end
  endtask

  task automatic test_async_reset();
    or32 = 1'b0;
    iv32 = 1'b1;
    ii32 = 32'h00309093;
    it32 = 32'd500;
    step();
    it32 = 32'd501;
    step();
    iv32 = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1 || ot32 !== 32'h0) begin
      n_bad++;
      $display("FAIL async reset: got valid=%b ready=%b tag=%h expected 0/1/0", ov32, ir32, ot32);
    end
    step();
    rst_n = 1'b1;
    step();
    or32 = 1'b1;
    iv32 = 1'b1;
    ii32 = 32'h123452B7;
    it32 = 32'd600;
    step();
    iv32 = 1'b0;
    n_cmp++;
    if (ov32 !== 1'b1 || oi32 !== 32'h12345000 || of32 !== 3'd4 || ot32 !== 32'd600) begin
      n_bad++;
      $display("FAIL post-reset accept: got valid=%b imm=%h fmt=%0d tag=%0d expected 1/12345000/4/600",
               ov32, oi32, of32, ot32);
    end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    iv32 = 1'b0; ii32 = '0; it32 = '0; or32 = 1'b0;
    iv64 = 1'b0; ii64 = '0; it64 = '0; or64 = 1'b0;
    test_reset();
    test_stream32();
    test_stream64();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
